// File: rtl/hash_reduce_if.sv
// Window-product bus into hash_reduce and the hashed result coming back out.
interface hash_reduce_if #(
  parameter int HASH_BITS = 16,
  parameter int TAG_W     = 8
);
  logic                 in_valid;
  logic [3:0]           in_len;
  logic                 in_inv;
  logic [TAG_W-1:0]     in_tag;
  logic [511:0]         prod;
  logic [511:0]         prod_1sc;
  logic [383:0]         msk;
  logic [383:0]         msk_1sc;
  logic                 out_valid;
  logic [HASH_BITS-1:0] out_hash;
  logic [3:0]           out_len;
  logic [TAG_W-1:0]     out_tag;
  logic [31:0]          hash_count;

  modport master (
    output in_valid, in_len, in_inv, in_tag, prod, prod_1sc, msk, msk_1sc,
    input  out_valid, out_hash, out_len, out_tag, hash_count
  );

  modport slave (
    input  in_valid, in_len, in_inv, in_tag, prod, prod_1sc, msk, msk_1sc,
    output out_valid, out_hash, out_len, out_tag, hash_count
  );
endinterface

// File: rtl/hash_reduce.sv
// Length-masked shift-add of per-chunk 16x16 partial products into a 64-bit
// product, emitting its top HASH_BITS bits; 3-stage pipeline, no stall.
module hash_reduce_lane #(
   parameter int IDX = 0
) (
   input  logic [3:0]        len_c,
   input  logic              inv,
   input  logic [3:0][31:0]  prod,
   input  logic [3:0][31:0]  prod_1sc,
   input  logic [3:0][23:0]  msk,
   input  logic [3:0][23:0]  msk_1sc,
   output logic [3:0][63:0]  term
);
   localparam int         RANK     = 3 - IDX;
   localparam logic [3:0] FULL_MIN = 4'(2*RANK + 2);
   localparam logic [3:0] HIGH_LEN = 4'(2*RANK + 1);

   logic full, high;
   assign full = (len_c >= FULL_MIN);
   assign high = (len_c == HIGH_LEN);

   // Terms landing at or above bit 64 never reach the truncated product.
   for (genvar j = 0; j < 4; j++) begin : g_term
      if (IDX + j <= 3) begin : g_live
         logic [31:0] sel;
         always_comb begin
            sel = '0;
            if (full)      sel = inv ? prod_1sc[j] : prod[j];
            else if (high) sel = {(inv ? msk_1sc[j] : msk[j]), 8'h00};
         end
         assign term[j] = {32'h0, sel} << (16*(IDX + j));
      end else begin : g_dead
         logic unused_t;
         assign unused_t = ^{prod[j], prod_1sc[j], msk[j], msk_1sc[j]};
         assign term[j]  = '0;
      end
   end
endmodule

module hash_reduce #(
   parameter int HASH_BITS = 16,
   parameter int TAG_W     = 8
) (
   input logic        clk,
   input logic        rst_n,
   hash_reduce_if.slave bus
);
   localparam int NUM_LANES = 4;
   localparam int STAGES    = 3;
   localparam int NT        = 10;

   typedef struct packed {
      logic [3:0]       len;
      logic [TAG_W-1:0] tag;
   } side_t;

   logic [NUM_LANES-1:0][3:0][31:0] prod_a, prod_b;
   logic [NUM_LANES-1:0][3:0][23:0] msk_a, msk_b;
   logic [NUM_LANES-1:0][3:0][63:0] tm;
   logic [3:0]                      len_c;

   assign prod_a = bus.prod;
   assign prod_b = bus.prod_1sc;
   assign msk_a  = bus.msk;
   assign msk_b  = bus.msk_1sc;
   assign len_c  = (bus.in_len > 4'd8) ? 4'd8 : bus.in_len;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      hash_reduce_lane #(.IDX(i)) u_lane (
         .len_c    (len_c),
         .inv      (bus.in_inv),
         .prod     (prod_a[i]),
         .prod_1sc (prod_b[i]),
         .msk      (msk_a[i]),
         .msk_1sc  (msk_b[i]),
         .term     (tm[i])
      );
   end

   // Ordered by shift group k=i+j: [0] k0, [2:1] k1, [5:3] k2, [9:6] k3.
   logic [NT-1:0][63:0] t_nxt;
   assign t_nxt = {tm[3][0], tm[2][1], tm[1][2], tm[0][3],
                   tm[2][0], tm[1][1], tm[0][2],
                   tm[1][0], tm[0][1],
                   tm[0][0]};

   logic unused_tm;
   assign unused_tm = ^{tm[1][3], tm[2][2], tm[2][3], tm[3][1], tm[3][2], tm[3][3]};

   logic [STAGES:1]       vld_q;
   logic [STAGES:0]       vld_pipe;
   side_t [STAGES:1]      side_q;
   logic [NT-1:0][63:0]   s1_t;
   logic [3:0][63:0]      s2_ps;
   logic [HASH_BITS-1:0]  hash_q;
   logic [31:0]           cnt_q;
   logic [63:0]           p_sum;

   assign vld_pipe = {vld_q, bus.in_valid};
   assign p_sum    = s2_ps[0] + s2_ps[1] + s2_ps[2] + s2_ps[3];

   logic unused_lo;
   assign unused_lo = ^p_sum[63-HASH_BITS:0];

   // Each stage loads only on a valid slot so outputs hold between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         side_q <= '0;
         s1_t   <= '0;
         s2_ps  <= '0;
         hash_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q <= vld_pipe[STAGES-1:0];
         if (vld_pipe[0]) begin
            s1_t      <= t_nxt;
            side_q[1] <= '{len: len_c, tag: bus.in_tag};
         end
         if (vld_pipe[1]) begin
            s2_ps[0]  <= s1_t[0] + s1_t[1] + s1_t[2];
            s2_ps[1]  <= s1_t[3] + s1_t[4] + s1_t[5];
            s2_ps[2]  <= s1_t[6] + s1_t[7];
            s2_ps[3]  <= s1_t[8] + s1_t[9];
            side_q[2] <= side_q[1];
         end
         if (vld_pipe[2]) begin
            hash_q    <= p_sum[63 -: HASH_BITS];
            side_q[3] <= side_q[2];
            cnt_q     <= cnt_q + 32'd1;
         end
      end
   end

   assign bus.out_valid  = vld_q[STAGES];
   assign bus.out_hash   = hash_q;
   assign bus.out_len    = side_q[STAGES].len;
   assign bus.out_tag    = side_q[STAGES].tag;
   assign bus.hash_count = cnt_q;
endmodule
